// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle datapath and its sequencing FSM.
// The datapath side (master) supplies instruction fields and status flags.
// The controller side (slave) returns the per-cycle control strobes.
interface multicycle_control_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       Zero;
    logic       mem_ready;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       Branch;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ImmSrc;
    logic       illegal;
    logic [3:0] state;

    modport master (
        output op, funct3, Zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Branch,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal, state
    );

    modport slave (
        input  op, funct3, Zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Branch,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore sequencer for a multicycle RV32 subset (load/store, R/I ALU, jal, beq/bne).
//
// state    | meaning
// ---------+---------------------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC+4 once memory is ready
// DECODE   | read registers, precompute branch target into ALUOut
// MEMADR   | ALUOut <= rs1 + imm (load or store address)
// MEMREAD  | read data memory at ALUOut, wait for mem_ready
// MEMWB    | rd <= loaded data
// MEMWRITE | write data memory at ALUOut, wait for mem_ready
// EXECUTER | ALUOut <= rs1 op rs2
// ALUWB    | rd <= ALUOut
// EXECUTEI | ALUOut <= rs1 op imm
// JAL      | PC <= target, ALUOut <= OldPC+4
// BRANCH   | compare rs1/rs2, PC <= target when taken
module multicycle_control (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.slave  bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        ALUWB    = 4'd7,
        EXECUTEI = 4'd8,
        JAL      = 4'd9,
        BRANCH   = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t state_q;
    state_t state_d;

    logic pc_write;
    logic ir_write;
    logic mem_write;
    logic reg_write;
    logic branch_taken;

    assign branch_taken = ((bus.funct3 == 3'b000) &  bus.Zero) |
                          ((bus.funct3 == 3'b001) & ~bus.Zero);

    // State register; reset returns to FETCH without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore outputs; codes outside the enum fall back to FETCH.
    always_comb begin
        state_d       = FETCH;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.Branch    = 1'b0;
        bus.ResultSrc = 2'b00;
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b00;
        bus.ALUOp     = 2'b00;
        bus.ImmSrc    = 2'b00;
        bus.illegal   = 1'b0;

        case (state_q)
            FETCH: begin
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                pc_write      = bus.mem_ready;
                ir_write      = bus.mem_ready;
                state_d       = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
                bus.ImmSrc  = 2'b10;
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECUTER;
                    OP_ITYPE:          state_d = EXECUTEI;
                    OP_JAL:            state_d = JAL;
                    OP_BRANCH:         state_d = BRANCH;
                    default: begin
                        state_d     = FETCH;
                        bus.illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                if (bus.op == OP_STORE) begin
                    bus.ImmSrc = 2'b01;
                    state_d    = MEMWRITE;
                end else begin
                    state_d    = MEMREAD;
                end
            end
            MEMREAD: begin
                bus.AdrSrc = 1'b1;
                state_d    = bus.mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                reg_write     = 1'b1;
                state_d       = FETCH;
            end
            MEMWRITE: begin
                bus.AdrSrc = 1'b1;
                mem_write  = 1'b1;
                state_d    = bus.mem_ready ? FETCH : MEMWRITE;
            end
            EXECUTER: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUOp   = 2'b10;
                state_d     = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            EXECUTEI: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                bus.ALUOp   = 2'b10;
                state_d     = ALUWB;
            end
            JAL: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                bus.ImmSrc  = 2'b11;
                pc_write    = 1'b1;
                state_d     = ALUWB;
            end
            BRANCH: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUOp   = 2'b01;
                bus.ImmSrc  = 2'b10;
                bus.Branch  = 1'b1;
                pc_write    = branch_taken;
                state_d     = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Architectural write strobes are masked while reset is held so that a
    // ready memory cannot commit anything before sequencing restarts.
    assign bus.PCWrite  = pc_write  & rst_n;
    assign bus.IRWrite  = ir_write  & rst_n;
    assign bus.MemWrite = mem_write & rst_n;
    assign bus.RegWrite = reg_write & rst_n;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each vector pushes its hand-derived
// expected control word; an independent monitor pops and compares it.
module tb_multicycle_control;
    logic clk;
    logic rst_n;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic       br;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] aop;
        logic [1:0] imm;
        logic       ill;
    } ctl_t;

    typedef struct {
        string name;
        ctl_t  exp;
    } sb_entry_t;

    sb_entry_t sb[$];
    int checks = 0;
    int errors = 0;
    event chk_ev;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] ADD  = 7'b0110011;
    localparam logic [6:0] ADDI = 7'b0010011;
    localparam logic [6:0] JALO = 7'b1101111;
    localparam logic [6:0] BR   = 7'b1100011;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed per-state control values from the state table; the input-dependent
    // fields (PCWrite, IRWrite, ImmSrc, illegal) come from each vector.
    function automatic ctl_t expv(logic [3:0] s, logic pcw, logic irw,
                                  logic [1:0] imm, logic ill);
        ctl_t e;
        e = '0;
        e.st = s;
        case (s)
            4'd0:  begin e.rs = 2'b10; e.sb = 2'b10; end
            4'd1:  begin e.sa = 2'b01; e.sb = 2'b01; end
            4'd2:  begin e.sa = 2'b10; e.sb = 2'b01; end
            4'd3:  begin e.adr = 1'b1; end
            4'd4:  begin e.rs = 2'b01; e.rw = 1'b1; end
            4'd5:  begin e.adr = 1'b1; e.mw = 1'b1; end
            4'd6:  begin e.sa = 2'b10; e.aop = 2'b10; end
            4'd7:  begin e.rw = 1'b1; end
            4'd8:  begin e.sa = 2'b10; e.sb = 2'b01; e.aop = 2'b10; end
            4'd9:  begin e.sa = 2'b01; e.sb = 2'b10; end
            4'd10: begin e.sa = 2'b10; e.aop = 2'b01; e.br = 1'b1; end
            default: ;
        endcase
        e.pcw = pcw;
        e.irw = irw;
        e.imm = imm;
        e.ill = ill;
        return e;
    endfunction

    task automatic check_one();
        sb_entry_t en;
        ctl_t act;
        if (sb.size() != 0) begin
            en  = sb.pop_front();
            act = {bus.state, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite,
                   bus.RegWrite, bus.Branch, bus.ResultSrc, bus.ALUSrcA,
                   bus.ALUSrcB, bus.ALUOp, bus.ImmSrc, bus.illegal};
            checks++;
            if (act !== en.exp) begin
                errors++;
                $display("FAIL %s: got state=%0d word=%h, want state=%0d word=%h",
                         en.name, act.st, act, en.exp.st, en.exp);
            end
        end
    endtask

    // Monitor: outputs are presented every cycle; compare at the falling edge.
    always @(negedge clk) check_one();
    // Monitor path for asynchronous events between clock edges.
    always @(chk_ev) check_one();

    task automatic drive(logic [6:0] o, logic [2:0] f, logic z, logic mr);
        bus.op        = o;
        bus.funct3    = f;
        bus.Zero      = z;
        bus.mem_ready = mr;
    endtask

    task automatic step(string nm, logic [6:0] o, logic [2:0] f, logic z, logic mr,
                        logic [3:0] es, logic pcw, logic irw, logic [1:0] imm,
                        logic ill);
        sb_entry_t en;
        @(posedge clk);
        #1;
        drive(o, f, z, mr);
        en.name = nm;
        en.exp  = expv(es, pcw, irw, imm, ill);
        sb.push_back(en);
    endtask

    task automatic async_check(string nm, logic [3:0] es);
        sb_entry_t en;
        en.name = nm;
        en.exp  = expv(es, 1'b0, 1'b0, 2'b00, 1'b0);
        sb.push_back(en);
        -> chk_ev;
        #0;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(7'd0, 3'd0, 1'b0, 1'b1);
        #2;
        async_check("reset_state_ready_high", 4'd0);
        step("reset_hold", 7'd0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge clk); #1; rst_n = 1'b1;

        // add: 0,1,6,7
        step("add_fetch",   ADD, 3'd0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 2'b00, 1'b0);
        step("add_decode",  ADD, 3'd0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 2'b10, 1'b0);
        step("add_exec",    ADD, 3'd0, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 2'b00, 1'b0);
        step("add_aluwb",   ADD, 3'd0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 2'b00, 1'b0);

        // lw with memory stalled two cycles: 0,1,2,3,3,3,4
        step("lw_fetch",    LW, 3'd2, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 2'b00, 1'b0);
        step("lw_decode",   LW, 3'd2, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 2'b10, 1'b0);
        step("lw_memadr",   LW, 3'd2, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 2'b00, 1'b0);
        step("lw_read_w0",  LW, 3'd2, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 2'b00, 1'b0);
        step("lw_read_w1",  LW, 3'd2, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 2'b00, 1'b0);
        step("lw_read_rdy", LW, 3'd2, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 2'b00, 1'b0);
        step("lw_memwb",    LW, 3'd2, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 2'b00, 1'b0);

        // sw with instruction fetch stalled three cycles, one write wait
        step("sw_fetch_w0", SW, 3'd2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0);
        step("sw_fetch_w1", SW, 3'd2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0);
        step("sw_fetch_w2", SW, 3'd2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0);
        step("sw_fetch",    SW, 3'd2, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 2'b00, 1'b0);
        step("sw_decode",   SW, 3'd2, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 2'b10, 1'b0);
        step("sw_memadr",   SW, 3'd2, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 2'b01, 1'b0);
        step("sw_write_w0", SW, 3'd2, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 2'b00, 1'b0);
        step("sw_write",    SW, 3'd2, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 2'b00, 1'b0);

        // jal: 0,1,9,7
        step("jal_fetch",   JALO, 3'd0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 2'b00, 1'b0);
        step("jal_decode",  JALO, 3'd0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 2'b10, 1'b0);
        step("jal_jal",     JALO, 3'd0, 1'b0, 1'b1, 4'd9, 1'b1, 1'b0, 2'b11, 1'b0);
        step("jal_aluwb",   JALO, 3'd0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 2'b00, 1'b0);

        // beq taken
        step("beq_fetch",   BR, 3'b000, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 2'b00, 1'b0);
        step("beq_decode",  BR, 3'b000, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 2'b10, 1'b0);
        step("beq_taken",   BR, 3'b000, 1'b1, 1'b1, 4'd10, 1'b1, 1'b0, 2'b10, 1'b0);
        // bne with Zero=1: not taken
        step("bne_fetch",   BR, 3'b001, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 2'b00, 1'b0);
        step("bne_decode",  BR, 3'b001, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 2'b10, 1'b0);
        step("bne_not_tkn", BR, 3'b001, 1'b1, 1'b1, 4'd10, 1'b0, 1'b0, 2'b10, 1'b0);
        // bne with Zero=0: taken
        step("bne2_fetch",  BR, 3'b001, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 2'b00, 1'b0);
        step("bne2_decode", BR, 3'b001, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 2'b10, 1'b0);
        step("bne_taken",   BR, 3'b001, 1'b0, 1'b1, 4'd10, 1'b1, 1'b0, 2'b10, 1'b0);
        // unsupported branch funct3 never writes PC
        step("blt_fetch",   BR, 3'b100, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 2'b00, 1'b0);
        step("blt_decode",  BR, 3'b100, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 2'b10, 1'b0);
        step("blt_no_pcw",  BR, 3'b100, 1'b1, 1'b1, 4'd10, 1'b0, 1'b0, 2'b10, 1'b0);

        // illegal opcode returns to FETCH with a one-cycle pulse
        step("ill_fetch",   7'd0, 3'd0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 2'b00, 1'b0);
        step("ill_decode",  7'd0, 3'd0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 2'b10, 1'b1);

        // addi: 0,1,8,7
        step("addi_fetch",  ADDI, 3'd0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 2'b00, 1'b0);
        step("addi_decode", ADDI, 3'd0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 2'b10, 1'b0);
        step("addi_exec",   ADDI, 3'd0, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 2'b00, 1'b0);
        step("addi_aluwb",  ADDI, 3'd0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 2'b00, 1'b0);

        // store interrupted by reset while waiting in MEMWRITE
        step("rs_fetch",    SW, 3'd2, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 2'b00, 1'b0);
        step("rs_decode",   SW, 3'd2, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 2'b10, 1'b0);
        step("rs_memadr",   SW, 3'd2, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 2'b01, 1'b0);
        step("rs_write",    SW, 3'd2, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        async_check("async_reset_in_memwrite", 4'd0);
        step("rs_hold_rdy", SW, 3'd2, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0);
        step("rs_hold",     SW, 3'd2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge clk); #1; rst_n = 1'b1;
        step("rs_idle",     ADD, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0);
        step("rs_refetch",  ADD, 3'd0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 2'b00, 1'b0);
        step("rs_decode2",  ADD, 3'd0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 2'b10, 1'b0);
        step("rs_exec",     ADD, 3'd0, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 2'b00, 1'b0);

        @(negedge clk); #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
